pc_unit: RTL



---
 rtl/pc_unit_pkg.sv | 17 +
 rtl/pc_ret_stack.sv | 62 ++++++
 rtl/pc_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program counter stage: the op encoding produced by
// the request decode and the default address/stack sizes.
package pc_unit_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    // Encoded in priority order; OP_HOLD covers the stalled case (en=0).
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_LOAD = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } pc_op_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: DEPTH entries of WIDTH bits, push/pop at sp, top of stack
// at sp-1. Pushes while full and pops while empty are dropped.
module pc_ret_stack
    import pc_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       full,
    output logic                       empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [SPW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok, pop_ok;
    logic [AW-1:0]    wr_idx, rd_idx;

    assign full   = (sp_q == SPW'(DEPTH));
    assign empty  = (sp_q == '0);
    assign sp     = sp_q;
    // Pop wins if both are requested, matching ret-over-call priority upstream.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & ~full & ~pop_ok;
    assign wr_idx  = sp_q[AW-1:0];
    assign rd_idx  = AW'(sp_q - 1'b1);
    assign dout    = empty ? '0 : mem_q[rd_idx];

    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (pop_ok) begin
            sp_d = sp_q - 1'b1;
        end else if (push_ok) begin
            sp_d          = sp_q + 1'b1;
            mem_d[wr_idx] = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter stage: decodes ret/call/load/increment requests, selects the
// next fetch address and holds the return stack plus sticky overflow/underflow.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int          WIDTH     = DEF_WIDTH,
    parameter int          DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   load,
    input  logic                   call,
    input  logic                   ret,
    input  logic [WIDTH-1:0]       target,
    output logic [WIDTH-1:0]       pc,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   stack_full,
    output logic                   stack_empty,
    output logic                   ovf,
    output logic                   unf
);

    pc_op_e           op;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] sel_jump, sel_ret;
    logic [WIDTH-1:0] stack_dout;

    always_comb begin
        op = OP_HOLD;
        if (en) begin
            if (ret)       op = OP_RET;
            else if (call) op = OP_CALL;
            else if (load) op = OP_LOAD;
            else           op = OP_INC;
        end
    end

    assign pc_inc = pc_q + 1'b1;

    // 2-way select chain, lowest priority first; a ret on an empty stack falls
    // through to the increment path.
    assign sel_jump = ((op == OP_CALL) || (op == OP_LOAD)) ? target : pc_inc;
    assign sel_ret  = ((op == OP_RET) && !stack_empty) ? stack_dout : sel_jump;
    assign pc_d     = (op == OP_HOLD) ? pc_q : sel_ret;

    assign ovf_d = ovf_q | ((op == OP_CALL) & stack_full);
    assign unf_d = unf_q | ((op == OP_RET) & stack_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (op == OP_CALL),
        .pop   (op == OP_RET),
        .din   (pc_inc),
        .dout  (stack_dout),
        .sp    (sp),
        .full  (stack_full),
        .empty (stack_empty)
    );

    assign pc  = pc_q;
    assign ovf = ovf_q;
    assign unf = unf_q;

endmodule
